// File: rtl/synapse_pkg.sv
// synapse_pkg: shared defaults and sizing helpers for the synapse array
package synapse_pkg;
    localparam int N_CH_DEF = 4;
    localparam int MAX_DELAY_DEF = 8;
    localparam int DLY_W_DEF = 4;
    localparam int W_W_DEF = 4;
    localparam int DEFAULT_DELAY_DEF = 2;
    localparam int DEFAULT_WEIGHT_DEF = 1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int SUM_W_DEF = W_W_DEF + clog2(N_CH_DEF);
endpackage

// File: rtl/synapse_delay_ch.sv
// synapse_delay_ch: one synapse channel with a programmable delay line and a signed weight
module synapse_delay_ch #(
    parameter int MAX_DELAY = 8,
    parameter int DLY_W = 4,
    parameter int W_W = 4,
    parameter int DEFAULT_DELAY = 2,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             we,
    input  logic [DLY_W-1:0] delay_in,
    input  logic [W_W-1:0]   weight_in,
    output logic             spike_out,
    output logic [W_W-1:0]   weight
);
    logic [MAX_DELAY-1:0] sr;
    logic [DLY_W-1:0] delay;
    logic [DLY_W-1:0] tap;
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            delay <= DLY_W'(DEFAULT_DELAY);
            weight <= W_W'(DEFAULT_WEIGHT);
        end else if (we) begin
            sr <= '0;
            delay <= delay_in;
            weight <= weight_in;
        end else begin
            sr <= {sr[MAX_DELAY-2:0], spike};
        end
    end
    assign tap = (delay == '0) ? '0 :
                 (delay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY - 1) : delay - DLY_W'(1);
    always_comb begin
        spike_out = 1'b0;
        for (int k = 0; k < MAX_DELAY; k++)
            if (tap == DLY_W'(k)) spike_out = sr[k];
    end
endmodule

// File: rtl/synapse_array.sv
// synapse_array: bank of delayed, weighted synapses summed into a registered postsynaptic current
module synapse_array import synapse_pkg::*; #(
    parameter int N_CH = N_CH_DEF,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DLY_W = DLY_W_DEF,
    parameter int W_W = W_W_DEF,
    parameter int DEFAULT_DELAY = DEFAULT_DELAY_DEF,
    parameter int DEFAULT_WEIGHT = DEFAULT_WEIGHT_DEF,
    localparam int CH_W = clog2(N_CH),
    localparam int SUM_W = W_W + clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         spike_in,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [DLY_W-1:0]        cfg_delay,
    input  logic [W_W-1:0]          cfg_weight,
    output logic [N_CH-1:0]         spike_out,
    output logic signed [SUM_W-1:0] psc_out,
    output logic                    psc_valid
);
    logic [W_W-1:0] weight [N_CH];
    logic [N_CH-1:0] we;
    logic signed [SUM_W-1:0] sum;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign we[i] = cfg_we && cfg_ch == CH_W'(i);
        synapse_delay_ch #(
            .MAX_DELAY(MAX_DELAY),
            .DLY_W(DLY_W),
            .W_W(W_W),
            .DEFAULT_DELAY(DEFAULT_DELAY),
            .DEFAULT_WEIGHT(DEFAULT_WEIGHT)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .spike(spike_in[i]),
            .we(we[i]),
            .delay_in(cfg_delay),
            .weight_in(cfg_weight),
            .spike_out(spike_out[i]),
            .weight(weight[i])
        );
    end
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++)
            if (spike_out[i]) sum = sum + SUM_W'($signed(weight[i]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_out <= '0;
            psc_valid <= 1'b0;
        end else begin
            psc_out <= sum;
            psc_valid <= |spike_out;
        end
    end
endmodule

// File: tb/tb_synapse_array.sv
// tb_synapse_array: directed stimulus with queued expectations checked by a per-cycle monitor
module tb_synapse_array;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] spike_in;
    logic cfg_we;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_delay;
    logic [3:0] cfg_weight;
    logic [3:0] spike_out;
    logic signed [5:0] psc_out;
    logic psc_valid;

    typedef struct {int c; logic [3:0] m;} sev_t;
    typedef struct {int c; int v;} pev_t;
    sev_t sq[$];
    pev_t pq[$];
    int cyc = 0;
    int total = 0;
    int passed = 0;
    bit armed = 0;
    int k;

    synapse_array dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_delay(cfg_delay), .cfg_weight(cfg_weight), .spike_out(spike_out),
        .psc_out(psc_out), .psc_valid(psc_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        total++;
        if (ok) passed++;
        else $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    endtask

    task automatic expect_at(input int c, input logic [3:0] m, input int v);
        sq.push_back('{c, m});
        pq.push_back('{c + 1, v});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] m);
        spike_in = m;
        @(negedge clk);
        spike_in = 4'b0;
    endtask

    task automatic cfg(input int ch, input int d, input int w);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_delay = 4'(d);
        cfg_weight = 4'(w);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            logic [3:0] em;
            bit ev;
            int ep;
            em = (sq.size() != 0 && sq[0].c == cyc) ? sq[0].m : 4'b0;
            if (em != 4'b0) void'(sq.pop_front());
            chk(spike_out == em, "spike_out", int'(spike_out), int'(em));
            ev = pq.size() != 0 && pq[0].c == cyc;
            ep = ev ? pq[0].v : 0;
            if (ev) void'(pq.pop_front());
            chk(psc_valid == ev, "psc_valid", int'(psc_valid), int'(ev));
            chk(int'(psc_out) == ep, "psc_out", int'(psc_out), ep);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: cycle %0d reached without finishing, expected under 10000", cyc);
        $fatal(1);
    end

    initial begin
        int dtab[5] = '{0, 1, 5, 8, 15};
        int ltab[5] = '{1, 1, 5, 8, 8};
        bit train[5] = '{1, 0, 1, 1, 0};
        rst = 1'b1;
        spike_in = 4'b0;
        cfg_we = 1'b0;
        cfg_ch = 2'b0;
        cfg_delay = 4'b0;
        cfg_weight = 4'b0;
        idle(3);
        armed = 1;
        chk(spike_out == 4'b0 && psc_out == 6'sd0 && !psc_valid, "reset outputs",
            int'({spike_out, psc_out, psc_valid}), 0);
        rst = 1'b0;
        idle(2);
        // defaults: delay 2, weight 1
        k = cyc + 1;
        expect_at(k + 1, 4'b0001, 1);
        drive(4'b0001);
        idle(4);
        // delay sweep on channel 2 including clamp at both ends
        for (int i = 0; i < 5; i++) begin
            cfg(2, dtab[i], 1);
            k = cyc + 1;
            expect_at(k + ltab[i] - 1, 4'b0100, 1);
            drive(4'b0100);
            idle(10);
        end
        // spike train on channel 1 with delay 3
        cfg(1, 3, 1);
        k = cyc + 1;
        for (int j = 0; j < 5; j++) if (train[j]) expect_at(k + 2 + j, 4'b0010, 1);
        for (int j = 0; j < 5; j++) begin
            spike_in = {2'b0, train[j], 1'b0};
            @(negedge clk);
        end
        spike_in = 4'b0;
        idle(6);
        // weighted sums
        cfg(0, 2, 7);
        cfg(1, 2, -8);
        cfg(2, 2, 3);
        cfg(3, 2, -1);
        k = cyc + 1;
        expect_at(k + 1, 4'b1111, 1);
        drive(4'b1111);
        idle(3);
        for (int c = 0; c < 4; c++) cfg(c, 2, -8);
        k = cyc + 1;
        expect_at(k + 1, 4'b1111, -32);
        drive(4'b1111);
        idle(3);
        cfg(0, 2, 0);
        k = cyc + 1;
        expect_at(k + 1, 4'b0001, 0);
        drive(4'b0001);
        idle(3);
        // mid-flight reconfiguration of channel 0 with channel 3 running alongside
        cfg(0, 6, 1);
        cfg(3, 2, 5);
        k = cyc + 1;
        expect_at(k + 1, 4'b1000, 5);
        drive(4'b1001);
        @(negedge clk);
        expect_at(k + 3, 4'b1000, 5);
        spike_in = 4'b1000;
        cfg(0, 6, 1);
        spike_in = 4'b0;
        idle(8);
        // reset with spikes in flight, competing with a config write and new spikes
        for (int c = 0; c < 4; c++) cfg(c, 8, 2);
        drive(4'b1111);
        idle(2);
        rst = 1'b1;
        spike_in = 4'b1111;
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_delay = 4'd1;
        cfg_weight = 4'd7;
        @(negedge clk);
        rst = 1'b0;
        cfg_we = 1'b0;
        spike_in = 4'b0;
        chk(spike_out == 4'b0 && psc_out == 6'sd0 && !psc_valid, "post-reset outputs",
            int'({spike_out, psc_out, psc_valid}), 0);
        idle(10);
        k = cyc + 1;
        expect_at(k + 1, 4'b1111, 4);
        drive(4'b1111);
        idle(12);
        chk(sq.size() == 0 && pq.size() == 0, "drain", sq.size() + pq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
